receiver: RTL

RECEIVER -- requirements
Module: receiver

---
 rtl/rx_pkg.sv | 18 +
 rtl/receiver_if.sv | 29 ++
 rtl/rx_sync.sv | 31 +++
 rtl/receiver.sv | 131 +++++++++++++
 4 files changed

// File: rtl/rx_pkg.sv
`default_nettype none
// ============================================================================
// Package  : rx_pkg
// Brief    : Shared defaults and FSM state encoding for the serial receiver.
// Revision : 1.0 - initial release
// ============================================================================
package rx_pkg;

    localparam int c_SIZE_DEFAULT         = 8;
    localparam int c_CLKS_PER_BIT_DEFAULT = 8;

    localparam logic [1:0] c_IDLE      = 2'b00;
    localparam logic [1:0] c_STARTING  = 2'b01;
    localparam logic [1:0] c_RECEIVING = 2'b10;
    localparam logic [1:0] c_STOPPING  = 2'b11;

endpackage
`default_nettype wire

// File: rtl/receiver_if.sv
`default_nettype none
// ============================================================================
// Interface : receiver_if
// Brief     : Serial line and host-side signals of the receiver.
// Revision  : 1.0 - initial release
// ============================================================================
interface receiver_if
    import rx_pkg::*;
#(
    parameter int SIZE = c_SIZE_DEFAULT
);
    logic            serial_in;
    logic            read_not_ready_in;
    logic [SIZE-1:0] RCV_datareg;
    logic            read_not_ready_out;
    logic            error1;
    logic            error2;

    modport slave (
        input  serial_in, read_not_ready_in,
        output RCV_datareg, read_not_ready_out, error1, error2
    );

    modport master (
        output serial_in, read_not_ready_in,
        input  RCV_datareg, read_not_ready_out, error1, error2
    );
endinterface
`default_nettype wire

// File: rtl/rx_sync.sv
`default_nettype none
// ============================================================================
// Module   : rx_sync
// Brief    : Two-flop synchronizer for the serial line, resets to idle-high.
//            Only built when RX_SYNC_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`ifdef RX_SYNC_EN
module rx_sync (
    input  wire logic clock,
    input  wire logic resetn,
    input  wire logic async_in,
    output logic      sync_out
);
    logic r_meta;
    logic r_sync;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= async_in;
            r_sync <= r_meta;
        end
    end

    assign sync_out = r_sync;
endmodule
`endif
`default_nettype wire

// File: rtl/receiver.sv
`default_nettype none
// ============================================================================
// Module   : receiver
// Brief    : Start/data/stop serial receiver with one-byte holding register,
//            overrun and framing flags. RX_SYNC_EN adds a 2-flop input sync.
// Revision : 1.0 - initial release
// ============================================================================
module receiver
    import rx_pkg::*;
#(
    parameter int SIZE         = c_SIZE_DEFAULT,
    parameter int CLKS_PER_BIT = c_CLKS_PER_BIT_DEFAULT
)(
    input  wire logic  clock,
    input  wire logic  resetn,
    receiver_if.slave  bus
);
    localparam int c_SCW = $clog2(CLKS_PER_BIT);
    localparam int c_BCW = $clog2(SIZE + 1);
    localparam logic [c_SCW-1:0] c_HALF_LAST = c_SCW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [c_SCW-1:0] c_BIT_LAST  = c_SCW'(CLKS_PER_BIT - 1);
    localparam logic [c_BCW-1:0] c_DATA_LAST = c_BCW'(SIZE - 1);

    logic             w_rx_line;
    logic             r_rx_prev;
    logic [1:0]       r_state;
    logic [c_SCW-1:0] r_smp_cnt;
    logic [c_BCW-1:0] r_bit_cnt;
    logic [SIZE-1:0]  r_shftreg;
    logic             r_done;
    logic             r_stop_bit;
    logic [SIZE-1:0]  r_datareg;
    logic             r_rnr;
    logic             r_err1;
    logic             r_err2;

`ifdef RX_SYNC_EN
    rx_sync u_rx_sync (
        .clock    (clock),
        .resetn   (resetn),
        .async_in (bus.serial_in),
        .sync_out (w_rx_line)
    );
`else
    assign w_rx_line = bus.serial_in;
`endif

    // Frame FSM; r_done pulses for one cycle after the stop bit is sampled
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state    <= c_IDLE;
            r_rx_prev  <= 1'b1;
            r_smp_cnt  <= '0;
            r_bit_cnt  <= '0;
            r_shftreg  <= '0;
            r_done     <= 1'b0;
            r_stop_bit <= 1'b1;
        end else begin
            r_rx_prev <= w_rx_line;
            r_done    <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (r_rx_prev && !w_rx_line) begin
                        r_state   <= c_STARTING;
                        r_smp_cnt <= '0;
                        r_bit_cnt <= '0;
                    end
                end
                c_STARTING: begin
                    if (r_smp_cnt == c_HALF_LAST) begin
                        r_smp_cnt <= '0;
                        r_state   <= w_rx_line ? c_IDLE : c_RECEIVING;
                    end else begin
                        r_smp_cnt <= r_smp_cnt + c_SCW'(1);
                    end
                end
                c_RECEIVING: begin
                    if (r_smp_cnt == c_BIT_LAST) begin
                        r_smp_cnt <= '0;
                        r_shftreg <= {w_rx_line, r_shftreg[SIZE-1:1]};
                        r_bit_cnt <= r_bit_cnt + c_BCW'(1);
                        if (r_bit_cnt == c_DATA_LAST) begin
                            r_state <= c_STOPPING;
                        end
                    end else begin
                        r_smp_cnt <= r_smp_cnt + c_SCW'(1);
                    end
                end
                c_STOPPING: begin
                    if (r_smp_cnt == c_BIT_LAST) begin
                        r_smp_cnt  <= '0;
                        r_stop_bit <= w_rx_line;
                        r_done     <= 1'b1;
                        r_state    <= c_IDLE;
                    end else begin
                        r_smp_cnt <= r_smp_cnt + c_SCW'(1);
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    // A completing frame takes priority over a simultaneous host read
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_datareg <= '0;
            r_rnr     <= 1'b0;
            r_err1    <= 1'b0;
            r_err2    <= 1'b0;
        end else if (r_done && (!r_rnr || bus.read_not_ready_in)) begin
            r_datareg <= r_shftreg;
            r_rnr     <= 1'b1;
            r_err1    <= 1'b0;
            r_err2    <= ~r_stop_bit;
        end else if (r_done) begin
            r_err1 <= 1'b1;
        end else if (bus.read_not_ready_in) begin
            r_rnr  <= 1'b0;
            r_err1 <= 1'b0;
            r_err2 <= 1'b0;
        end
    end

    assign bus.RCV_datareg        = r_datareg;
    assign bus.read_not_ready_out = r_rnr;
    assign bus.error1             = r_err1;
    assign bus.error2             = r_err2;

endmodule
`default_nettype wire
